// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pkg
// Description : Shared types and constants for the 8-digit seven-segment
//               scan controller. Holds the scan FSM state type, the frame
//               geometry, the blank segment pattern and a helper that turns
//               a digit index into an active-low anode select.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

  typedef enum logic [1:0] {
    GUARD = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2
  } scan_state_t;

  localparam int         NUM_DIG        = 8;
  localparam int         TICKS_PER_SLOT = 16;
  localparam logic [7:0] BLANK_PAT      = 8'hFF;

  // Active-low one-hot anode select for digit idx.
  function automatic logic [7:0] dig_an(input logic [2:0] idx);
    dig_an = ~(8'd1 << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : sseg_tick_gen
// Description : Free-running prescaler. Emits a one-cycle strobe on the last
//               cycle of every TICK_CYC-cycle period. Synchronous reset
//               restarts the period at count 0.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous active-high reset
//               tick_o - one-cycle strobe, high on the last cycle of a tick
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_tick_gen #(
  parameter int TICK_CYC = 3125
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int            CW   = (TICK_CYC > 2) ? $clog2(TICK_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_ctrl
// Description : Time-multiplexed scan controller for an 8-digit, common-anode
//               seven-segment display with per-digit enable and 16-step
//               brightness. A frame is 8 slots (one per digit), a slot is 16
//               ticks. Each slot opens with a one-tick guard, then `bright`
//               on-ticks, then off-ticks. Digit patterns are written into a
//               shadow bank and copied to the live bank at each frame
//               boundary so a frame never shows a mix of old and new data.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               wr_valid   - write request
//               wr_ready   - write accepted this cycle (low in commit cycle)
//               wr_addr    - digit index written
//               wr_data    - active-low segment pattern {dp,g..a}
//               digit_en   - per-digit enable, 0 blanks the digit
//               bright     - on-ticks per slot (0..15)
//               an         - active-low anode drive (registered)
//               sseg       - active-low segment drive (registered)
//               frame_tick - one-cycle pulse on the last cycle of slot 7
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int TICK_CYC = 3125,
  parameter int NUM_DIG  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] digit_en,
  input  logic [3:0] bright,
  output logic [7:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_SLOT - 1);
  localparam logic [2:0] LAST_DIG  = 3'(NUM_DIG - 1);

  logic        tick;
  logic        slot_end;
  logic        wr_fire;

  scan_state_t state_q, state_d;
  logic [3:0]  tick_idx_q, tick_idx_d;
  logic [2:0]  dig_idx_q, dig_idx_d;
  logic        slot_start_q;
  logic [3:0]  bright_l_q;
  logic        en_l_q;
  logic [7:0]  an_q, an_d;
  logic [7:0]  sseg_q, sseg_d;
  logic [7:0]  shadow_q [NUM_DIG];
  logic [7:0]  live_q   [NUM_DIG];

  sseg_tick_gen #(
    .TICK_CYC (TICK_CYC)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign slot_end   = tick && (tick_idx_q == LAST_TICK);
  assign frame_tick = slot_end && (dig_idx_q == LAST_DIG);
  // The commit cycle owns the shadow bank; a write offered then simply waits.
  assign wr_ready   = !frame_tick;
  assign wr_fire    = wr_valid && wr_ready;

  assign an   = an_q;
  assign sseg = sseg_q;

  always_comb begin
    tick_idx_d = tick ? tick_idx_q + 4'd1 : tick_idx_q;
    dig_idx_d  = slot_end ? dig_idx_q + 3'd1 : dig_idx_q;
  end

  // Phase boundaries always fall on tick strobes. The ON phase ends after
  // tick bright_l; a full-brightness slot skips OFF and goes straight back
  // to GUARD for the next slot.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        GUARD:   state_d = (bright_l_q == 4'd0) ? OFF : ON;
        ON: begin
          if (tick_idx_q == bright_l_q) begin
            state_d = (bright_l_q == LAST_TICK) ? GUARD : OFF;
          end
        end
        OFF: begin
          if (tick_idx_q == LAST_TICK) begin
            state_d = GUARD;
          end
        end
        default: state_d = GUARD;
      endcase
    end
  end

  always_comb begin
    an_d   = BLANK_PAT;
    sseg_d = BLANK_PAT;
    if ((state_q == ON) && en_l_q) begin
      an_d   = dig_an(dig_idx_q);
      sseg_d = live_q[dig_idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GUARD;
      tick_idx_q   <= 4'd0;
      dig_idx_q    <= 3'd0;
      // First cycle after reset is the first cycle of slot 0's guard tick.
      slot_start_q <= 1'b1;
      bright_l_q   <= 4'd0;
      en_l_q       <= 1'b0;
      an_q         <= BLANK_PAT;
      sseg_q       <= BLANK_PAT;
      for (int i = 0; i < NUM_DIG; i++) begin
        shadow_q[i] <= BLANK_PAT;
        live_q[i]   <= BLANK_PAT;
      end
    end else begin
      state_q      <= state_d;
      tick_idx_q   <= tick_idx_d;
      dig_idx_q    <= dig_idx_d;
      slot_start_q <= slot_end;
      an_q         <= an_d;
      sseg_q       <= sseg_d;

      // Slot settings are sampled once, so mid-slot changes wait a slot.
      if (slot_start_q) begin
        bright_l_q <= bright;
        en_l_q     <= digit_en[dig_idx_q];
      end

      if (frame_tick) begin
        for (int i = 0; i < NUM_DIG; i++) begin
          live_q[i] <= shadow_q[i];
        end
      end

      if (wr_fire) begin
        shadow_q[wr_addr] <= wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan_ctrl
// Description : Self-checking bench for sseg_scan_ctrl with TICK_CYC=4.
//               A timing model derived from slot/tick arithmetic predicts
//               every output every cycle; slot-level vectors and hand-built
//               sequences check brightness, blanking, commit and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_ctrl;

  localparam int TC    = 4;
  localparam int SLOT  = 16 * TC;
  localparam int FRAME = 8 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] digit_en = 8'h00;
  logic [3:0] bright = 4'd0;
  logic [7:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  sseg_scan_ctrl #(
    .TICK_CYC (TC),
    .NUM_DIG  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .digit_en   (digit_en),
    .bright     (bright),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: t counts cycles since reset release.
  int         t;
  int         last_ft;
  logic [3:0] m_bl;
  logic       m_el;
  logic [7:0] m_shadow [8];
  logic [7:0] m_live   [8];
  logic [7:0] exp_an, exp_sseg;

  // Last sampled values
  logic [7:0] s_an, s_sseg;
  logic       s_ready, s_ft;
  int         s_t;

  typedef struct {
    logic [3:0] b;
    logic [7:0] en;
    int         chg_at;
    logic [3:0] chg_b;
    bit         cont;
    int         exp_on;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, want, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    last_ft = -1;
    m_bl = 4'd0;
    m_el = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 8'hFF;
      m_live[i]   = 8'hFF;
    end
    exp_an   = 8'hFF;
    exp_sseg = 8'hFF;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: compare outputs at negedge, then advance the model with
  // the inputs present at the rising edge.
  task automatic step();
    int pos, slot, tk;
    bit ft, on;
    pos  = t % SLOT;
    slot = (t / SLOT) % 8;
    tk   = pos / TC;
    ft   = (pos == SLOT - 1) && (slot == 7);
    @(negedge clk);
    chk("an", an, exp_an);
    chk("sseg", sseg, exp_sseg);
    chk("frame_tick", frame_tick, ft);
    chk("wr_ready", wr_ready, !ft);
    s_an = an; s_sseg = sseg; s_ready = wr_ready; s_ft = frame_tick; s_t = t;
    if (frame_tick === 1'b1) begin
      if (last_ft >= 0) chk("ft_period", t - last_ft, FRAME);
      last_ft = t;
    end
    @(posedge clk);
    if (pos == 0) begin
      m_bl = bright;
      m_el = digit_en[slot];
    end
    on       = m_el && (tk >= 1) && (tk <= int'(m_bl));
    exp_an   = on ? ~(8'd1 << slot) : 8'hFF;
    exp_sseg = on ? m_live[slot] : 8'hFF;
    if (ft) m_live = m_shadow;
    else if (wr_valid) m_shadow[wr_addr] = wr_data;
    t++;
    #1;
  endtask

  task automatic align(input int target);
    int n = 0;
    while ((t % FRAME) != target && n < FRAME + 8) begin
      step();
      n++;
    end
    if ((t % FRAME) != target) chk("align_timeout", t % FRAME, target);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    do begin
      step();
      n++;
    end while (s_ready !== 1'b1 && n < 4);
    wr_valid = 1'b0;
    if (s_ready !== 1'b1) chk("wr_timeout", s_ready, 1);
  endtask

  // Runs one slot and summarises its registered output window (slot pos
  // 1..63 plus pos 0 of the next slot). Unless cont is set, settings are
  // applied just before the slot's guard tick.
  task automatic run_slot(input vec_t v, output int on_cnt, output int first,
                          output logic [7:0] an_seen, output logic [7:0] sseg_seen,
                          output int slot);
    if (!v.cont) begin
      while ((t % SLOT) != SLOT - 1) step();
      bright = v.b; digit_en = v.en;
      step();
      step();
    end
    slot = (t / SLOT) % 8;
    on_cnt = 0; first = -1; an_seen = 8'hFF; sseg_seen = 8'hFF;
    for (int i = 1; i <= SLOT; i++) begin
      if (i == v.chg_at) bright = v.chg_b;
      step();
      if (s_an !== 8'hFF) begin
        on_cnt++;
        if (first < 0) first = i;
        an_seen = s_an;
        sseg_seen = s_sseg;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int on_cnt, first, slot, act, ftc, n;
    logic [7:0] a_seen, s_seen;
    vec_t v;

    vecs[0] = '{4'd7,  8'hFF, -1, 4'd0,  1'b0, 28};
    vecs[1] = '{4'd0,  8'hFF, -1, 4'd0,  1'b0, 0};
    vecs[2] = '{4'd15, 8'hFF, -1, 4'd0,  1'b0, 60};
    vecs[3] = '{4'd5,  8'hFF, 12, 4'd10, 1'b0, 20};
    vecs[4] = '{4'd10, 8'hFF, -1, 4'd0,  1'b1, 40};
    vecs[5] = '{4'd3,  8'h00, -1, 4'd0,  1'b0, 0};
    vecs[6] = '{4'd1,  8'hFF, -1, 4'd0,  1'b0, 4};

    model_reset();
    do_reset(3);

    // Reset state and delayed C0 write to digit 3
    bright = 4'd7; digit_en = 8'hFF;
    step();
    chk("reset_an", s_an, 8'hFF);
    chk("reset_sseg", s_sseg, 8'hFF);
    chk("reset_ready", s_ready, 1);
    wr(3'd3, 8'hC0);
    align(3 * SLOT - 1);
    v = '{4'd7, 8'hFF, -1, 4'd0, 1'b0, 28};
    run_slot(v, on_cnt, first, a_seen, s_seen, slot);
    chk("f0_d3_an", a_seen, 8'hF7);
    chk("f0_d3_sseg_uncommitted", s_seen, 8'hFF);
    align(3 * SLOT - 1);
    run_slot(v, on_cnt, first, a_seen, s_seen, slot);
    chk("f1_d3_an", a_seen, 8'hF7);
    chk("f1_d3_sseg", s_seen, 8'hC0);
    chk("f1_d3_on_cycles", on_cnt, 28);
    chk("f1_d3_first", first, 5);

    // Slot vectors: brightness extremes, mid-slot change, blanked digit
    for (int k = 0; k < 7; k++) begin
      run_slot(vecs[k], on_cnt, first, a_seen, s_seen, slot);
      chk($sformatf("vec%0d_on_cycles", k), on_cnt, vecs[k].exp_on);
      if (vecs[k].exp_on > 0) begin
        chk($sformatf("vec%0d_first", k), first, 5);
        chk($sformatf("vec%0d_an", k), a_seen, ~(32'd1 << slot) & 32'hFF);
      end
    end

    // Random stimulus against the model
    for (int i = 0; i < 3 * FRAME; i++) begin
      wr_valid = ($urandom_range(2) == 0);
      wr_addr  = 3'($urandom_range(7));
      wr_data  = 8'($urandom_range(255));
      if ($urandom_range(40) == 0) bright = 4'($urandom_range(15));
      if ($urandom_range(100) == 0) digit_en = 8'($urandom_range(255));
      step();
    end
    wr_valid = 1'b0;

    // Whole frame with every digit disabled
    align(FRAME - 1);
    digit_en = 8'h00; bright = 4'd9;
    step();
    step();
    act = 0; ftc = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (s_an !== 8'hFF) act++;
      if (s_ft === 1'b1) ftc++;
    end
    chk("blank_frame_active", act, 0);
    chk("ft_per_frame", ftc, 1);

    // Write held across the commit cycle
    digit_en = 8'hFF; bright = 4'd15;
    wr(3'd5, 8'h3C);
    align(FRAME - 1);
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 8'hA5;
    step();
    chk("commit_ready", s_ready, 0);
    step();
    chk("post_commit_ready", s_ready, 1);
    wr_valid = 1'b0;
    v = '{4'd15, 8'hFF, -1, 4'd0, 1'b0, 60};
    align(5 * SLOT - 1);
    run_slot(v, on_cnt, first, a_seen, s_seen, slot);
    chk("held_wr_not_yet_live", s_seen, 8'h3C);
    chk("full_bright_on_cycles", on_cnt, 60);
    align(5 * SLOT - 1);
    run_slot(v, on_cnt, first, a_seen, s_seen, slot);
    chk("held_wr_live", s_seen, 8'hA5);

    // Reset in slot 5 tick 9 with an uncommitted write pending
    align(4 * SLOT);
    wr(3'd0, 8'h12);
    align(5 * SLOT + 9 * TC);
    do_reset(1);
    step();
    chk("rst_an", s_an, 8'hFF);
    chk("rst_sseg", s_sseg, 8'hFF);
    n = 0;
    while (s_an === 8'hFF && n < SLOT) begin
      step();
      n++;
    end
    chk("rst_first_an", s_an, 8'hFE);
    chk("rst_first_at", s_t, 5);
    chk("rst_live_blank", s_sseg, 8'hFF);
    align(FRAME - 1);
    run_slot(v, on_cnt, first, a_seen, s_seen, slot);
    chk("rst_shadow_discarded", s_seen, 8'hFF);
    chk("rst_d0_an", a_seen, 8'hFE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
